// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic inter-stage pipeline register with valid/ready
//               handshake, optional 2-entry skid buffer, synchronous flush
//               and a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int CTRL_W      = 8,
    parameter int DATA_W      = 96,
    parameter int SKID_EN     = 1,
    parameter int CLR_DATA    = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_FULL2 = 2'd2;

    localparam logic [STALL_CNT_W-1:0] c_STALL_MAX = '1;
    localparam logic [STALL_CNT_W-1:0] c_STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_load_in;
    logic                   w_load_skid;
    logic                   w_head_from_skid;
    logic [CTRL_W-1:0]      r_head_ctrl;
    logic [DATA_W-1:0]      r_head_data;
    logic [CTRL_W-1:0]      r_skid_ctrl;
    logic [DATA_W-1:0]      r_skid_data;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign out_valid  = (r_state != c_EMPTY);
    // Bubbles must never carry live control bits downstream.
    assign out_ctrl   = out_valid ? r_head_ctrl : '0;
    assign out_data   = r_head_data;
    assign stall_cnt  = r_stall_cnt;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    generate
        if (SKID_EN != 0) begin : g_skid_ready
            logic r_in_ready;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) r_in_ready <= 1'b1;
                else      r_in_ready <= (w_state_nxt != c_FULL2);
            end
            assign in_ready = r_in_ready;
        end else begin : g_comb_ready
            assign in_ready = out_ready | ~out_valid;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_EMPTY;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_in        = 1'b0;
        w_load_skid      = 1'b0;
        w_head_from_skid = 1'b0;
        if (flush) begin
            w_state_nxt = c_EMPTY;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = c_ONE;
                        w_load_in   = 1'b1;
                    end
                end
                c_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_in = 1'b1;
                    end else if (w_in_fire && (SKID_EN != 0)) begin
                        w_state_nxt = c_FULL2;
                        w_load_skid = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = c_EMPTY;
                    end
                end
                c_FULL2: begin
                    if (w_out_fire) begin
                        w_state_nxt      = c_ONE;
                        w_head_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = c_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head_ctrl <= '0;
            r_head_data <= '0;
        end else if (flush) begin
            r_head_ctrl <= '0;
            if (CLR_DATA != 0) r_head_data <= '0;
        end else if (w_load_in) begin
            r_head_ctrl <= in_ctrl;
            r_head_data <= in_data;
        end else if (w_head_from_skid) begin
            r_head_ctrl <= r_skid_ctrl;
            r_head_data <= r_skid_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush) begin
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (w_load_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
        end
    end

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != c_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_STALL_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg; two instances (skid
//               buffer with data clear, and plain register with 4-bit counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CW  = 8;
    localparam int DWA = 96;
    localparam int DWB = 16;

    typedef logic [CW+DWA-1:0] ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst       = 1'b1;
    logic           flush     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b1;
    logic [CW-1:0]  in_ctrl   = '0;
    logic [DWA-1:0] in_data   = '0;

    logic           a_in_ready, a_out_valid;
    logic [CW-1:0]  a_out_ctrl;
    logic [DWA-1:0] a_out_data;
    logic [15:0]    a_stall;
    logic           b_in_ready, b_out_valid;
    logic [CW-1:0]  b_out_ctrl;
    logic [DWB-1:0] b_out_data;
    logic [3:0]     b_stall;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DWA), .SKID_EN(1), .CLR_DATA(1), .STALL_CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DWB), .SKID_EN(0), .CLR_DATA(0), .STALL_CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data[DWB-1:0]),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .stall_cnt(b_stall)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: in-order queues bounded by stage capacity.
    ent_t           qa[$];
    ent_t           qb[$];
    logic [DWA-1:0] da;
    logic [DWB-1:0] db;
    int             sa;
    int             sb;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        da = '0;
        db = '0;
        sa = 0;
        sb = 0;
    endtask

    task automatic check_all();
        logic [CW-1:0] ea_ctrl;
        logic [CW-1:0] eb_ctrl;
        ea_ctrl = '0;
        eb_ctrl = '0;
        if (qa.size() > 0) ea_ctrl = qa[0][CW+DWA-1:DWA];
        if (qb.size() > 0) eb_ctrl = qb[0][CW+DWA-1:DWA];
        chk("a_in_ready",  a_in_ready,  qa.size() < 2);
        chk("a_out_valid", a_out_valid, qa.size() > 0);
        chk("a_out_ctrl",  a_out_ctrl,  ea_ctrl);
        chk("a_out_data",  a_out_data,  da);
        chk("a_stall_cnt", a_stall,     sa);
        chk("b_in_ready",  b_in_ready,  out_ready || (qb.size() == 0));
        chk("b_out_valid", b_out_valid, qb.size() > 0);
        chk("b_out_ctrl",  b_out_ctrl,  eb_ctrl);
        chk("b_out_data",  b_out_data,  db);
        chk("b_stall_cnt", b_stall,     sb);
    endtask

    task automatic model_edge();
        bit   a_in, a_out, b_in, b_out;
        ent_t e;
        if (!rst) begin
            model_reset();
            return;
        end
        a_in  = in_valid && (qa.size() < 2);
        a_out = (qa.size() > 0) && out_ready;
        b_in  = in_valid && (out_ready || (qb.size() == 0));
        b_out = (qb.size() > 0) && out_ready;
        if ((qa.size() > 0) && !out_ready && (sa < 65535)) sa++;
        if ((qb.size() > 0) && !out_ready && (sb < 15)) sb++;
        e = {in_ctrl, in_data};
        if (flush) begin
            qa.delete();
            qb.delete();
            da = '0;
        end else begin
            if (a_out) void'(qa.pop_front());
            if (a_in) qa.push_back(e);
            if (qa.size() > 0) da = qa[0][DWA-1:0];
            if (b_out) void'(qb.pop_front());
            if (b_in) qb.push_back(e);
            if (qb.size() > 0) db = qb[0][DWB-1:0];
        end
    endtask

    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_a_out_data", a_out_data, 0);
        rst = 1'b1;

        // Streaming, one entry per cycle
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_ctrl  = CW'(i);
            in_data  = DWA'(i);
            tick();
            chk("stream_data", a_out_data, i);
            chk("stream_ready", a_in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        tick();

        // Stall with A, B, C offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'hA1; in_data = DWA'('hA);
        tick();
        in_ctrl   = 8'hB2; in_data = DWA'('hB);
        tick();
        chk("stall_full_ready", a_in_ready, 0);
        in_ctrl   = 8'hC3; in_data = DWA'('hC);
        tick();
        tick();
        chk("stall_cnt_a", a_stall, 3);
        chk("stall_cnt_b", b_stall, 3);
        out_ready = 1'b1;
        tick();
        chk("order_b", a_out_data, 'hB);
        tick();
        chk("order_c", a_out_data, 'hC);
        in_valid = 1'b0;
        tick();
        chk("drained", a_out_valid, 0);

        // Flush while holding two entries, with a coinciding offer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h5A; in_data = DWA'('hDEAD);
        tick();
        in_ctrl   = 8'h6B; in_data = DWA'('hBEEF);
        tick();
        flush     = 1'b1;
        in_ctrl   = 8'h7C; in_data = DWA'('hC0C0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("flush_a_valid", a_out_valid, 0);
        chk("flush_a_ctrl",  a_out_ctrl,  0);
        chk("flush_a_data",  a_out_data,  0);
        chk("flush_a_ready", a_in_ready,  1);
        chk("flush_b_valid", b_out_valid, 0);
        chk("flush_b_ctrl",  b_out_ctrl,  0);
        chk("flush_b_data",  b_out_data,  'hDEAD);
        tick();
        chk("flush_c_dropped", a_out_valid, 0);

        // Asynchronous reset while full
        in_valid = 1'b1;
        in_ctrl  = 8'h11; in_data = DWA'('h11);
        tick();
        in_ctrl  = 8'h22; in_data = DWA'('h22);
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_a_valid", a_out_valid, 0);
        chk("arst_a_ctrl",  a_out_ctrl,  0);
        chk("arst_a_data",  a_out_data,  0);
        chk("arst_a_ready", a_in_ready,  1);
        chk("arst_a_stall", a_stall,     0);
        chk("arst_b_stall", b_stall,     0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 8'h33; in_data = DWA'('h33);
        tick();
        chk("arst_first_entry", a_out_data, 'h33);
        in_valid = 1'b0;
        tick();

        // Counter saturation on the 4-bit instance
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h44; in_data = DWA'('h44);
        repeat (20) tick();
        chk("sat_b", b_stall, 15);
        chk("nosat_a", a_stall, 19);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (3) tick();

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_ctrl   = CW'($urandom);
            in_data   = {$urandom, $urandom, $urandom};
            tick();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
